// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the MNIST CNN front end.
// Image geometry and digit encoding are common to every pipeline stage.
package cnn_pkg;

    localparam int IMG_DIM    = 28;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;
    localparam int PIX_BITS   = 8;
    localparam int DIGIT_BITS = 4;

    localparam logic [DIGIT_BITS-1:0] DIGIT_ERR = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_STREAM = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

endpackage

// File: rtl/frame_ram.sv
// Single-port frame buffer with synchronous write and synchronous read.
// The array is left unreset so it maps onto block RAM.
module frame_ram #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 784,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rdata_q;

    // Port access: a write takes priority, otherwise an enabled cycle reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mnist_frame_streamer.sv
// Loads one image into the frame RAM, resets the CNN pipeline, streams the
// pixels contiguously and returns the comparator decision (or a timeout).
module mnist_frame_streamer #(
    parameter int DATA_BITS  = 8,
    parameter int IMG_PIXELS = 784,
    parameter int ADDR_BITS  = 10,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_valid,
    input  logic [DATA_BITS-1:0] pix_data,
    output logic                 pix_ready,
    output logic                 cnn_rst_n,
    output logic [DATA_BITS-1:0] cnn_data,
    input  logic                 cnn_valid,
    input  logic [3:0]           cnn_decision,
    output logic                 result_valid,
    output logic [3:0]           result_digit,
    output logic                 result_err,
    output logic                 busy
);

    import cnn_pkg::*;

    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [ADDR_BITS-1:0] LAST_PIX   = ADDR_BITS'(IMG_PIXELS - 1);
    localparam logic [TMR_W-1:0]     FLUSH_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]     TMR_LAST   = TMR_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  wr_cnt_q, wr_cnt_d;
    logic [ADDR_BITS-1:0]  rd_cnt_q, rd_cnt_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  pix_ready_q, pix_ready_d;
    logic                  cnn_rst_n_q, cnn_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  result_valid_q, result_valid_d;
    logic                  result_err_q, result_err_d;
    logic [3:0]            result_digit_q, result_digit_d;

    logic                  xfer_s;
    logic                  ram_en_s;
    logic                  ram_we_s;
    logic [ADDR_BITS-1:0]  ram_addr_s;
    logic [DATA_BITS-1:0]  ram_rdata_s;

    assign xfer_s = pix_valid & pix_ready_q;

    frame_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (IMG_PIXELS),
        .ADDR_BITS (ADDR_BITS)
    ) u_frame_ram (
        .clk   (clk),
        .en    (ram_en_s),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (pix_data),
        .rdata (ram_rdata_s)
    );

    // Next-state, counter, RAM port and output-register decode.
    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        tmr_d          = tmr_q;
        result_valid_d = 1'b0;
        result_digit_d = result_digit_q;
        result_err_d   = result_err_q;
        ram_en_s       = 1'b0;
        ram_we_s       = 1'b0;
        ram_addr_s     = wr_cnt_q;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (xfer_s) begin
                    ram_en_s = 1'b1;
                    ram_we_s = 1'b1;
                    if (wr_cnt_q == LAST_PIX) begin
                        wr_cnt_d = {ADDR_BITS{1'b0}};
                        state_d  = ST_FLUSH;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDR_BITS'(1);
                        state_d  = ST_LOAD;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_FLUSH: begin
                // The last reset cycle prefetches pixel 0 so it lands with cnn_rst_n rising.
                if (tmr_q == FLUSH_LAST) begin
                    tmr_d      = {TMR_W{1'b0}};
                    ram_en_s   = 1'b1;
                    ram_addr_s = {ADDR_BITS{1'b0}};
                    state_d    = ST_STREAM;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_STREAM: begin
                if (rd_cnt_q == LAST_PIX) begin
                    rd_cnt_d = {ADDR_BITS{1'b0}};
                    state_d  = ST_WAIT;
                end else begin
                    ram_en_s   = 1'b1;
                    ram_addr_s = rd_cnt_q + ADDR_BITS'(1);
                    rd_cnt_d   = rd_cnt_q + ADDR_BITS'(1);
                end
            end
            ST_WAIT: begin
                if (cnn_valid) begin
                    result_valid_d = 1'b1;
                    result_digit_d = cnn_decision;
                    result_err_d   = 1'b0;
                    tmr_d          = {TMR_W{1'b0}};
                    state_d        = ST_IDLE;
                end else if (tmr_q == TMR_LAST) begin
                    result_valid_d = 1'b1;
                    result_digit_d = DIGIT_ERR;
                    result_err_d   = 1'b1;
                    tmr_d          = {TMR_W{1'b0}};
                    state_d        = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pix_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        cnn_rst_n_d = (state_d == ST_STREAM) || (state_d == ST_WAIT);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_cnt_q       <= {ADDR_BITS{1'b0}};
            rd_cnt_q       <= {ADDR_BITS{1'b0}};
            tmr_q          <= {TMR_W{1'b0}};
            pix_ready_q    <= 1'b0;
            cnn_rst_n_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_digit_q <= 4'h0;
            result_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            tmr_q          <= tmr_d;
            pix_ready_q    <= pix_ready_d;
            cnn_rst_n_q    <= cnn_rst_n_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_digit_q <= result_digit_d;
            result_err_q   <= result_err_d;
        end
    end

    // RAM output is a register; gating keeps cnn_data at zero outside STREAM.
    assign cnn_data     = (state_q == ST_STREAM) ? ram_rdata_s : {DATA_BITS{1'b0}};
    assign pix_ready    = pix_ready_q;
    assign cnn_rst_n    = cnn_rst_n_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_digit = result_digit_q;
    assign result_err   = result_err_q;

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Self-checking bench for mnist_frame_streamer: timestamp-based reference
// model compared every cycle, plus directed literal checks.
module tb_mnist_frame_streamer;

    localparam int NPIX = 784;
    localparam int RST  = 2;
    localparam int TO   = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_ready;
    logic       cnn_rst_n;
    logic [7:0] cnn_data;
    logic       cnn_valid;
    logic [3:0] cnn_decision;
    logic       result_valid;
    logic [3:0] result_digit;
    logic       result_err;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int wr_seen = 0;
    int rv_seen = 0;

    // Reference model state: m_post counts cycles since the image finished loading.
    int         m_post, m_ld, w;
    logic [7:0] img [NPIX];
    logic       e_ready, e_crst, e_busy, e_rv, e_re;
    logic [7:0] e_data;
    logic [3:0] e_rd;

    mnist_frame_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .cnn_rst_n    (cnn_rst_n),
        .cnn_data     (cnn_data),
        .cnn_valid    (cnn_valid),
        .cnn_decision (cnn_decision),
        .result_valid (result_valid),
        .result_digit (result_digit),
        .result_err   (result_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_post = 0; m_ld = 0;
        e_ready = 1'b0; e_crst = 1'b0; e_busy = 1'b0; e_rv = 1'b0; e_re = 1'b0;
        e_data = 8'd0; e_rd = 4'd0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_post = 0; m_ld = 0;
                e_ready = 1'b0; e_crst = 1'b0; e_busy = 1'b0; e_rv = 1'b0; e_re = 1'b0;
                e_data = 8'd0; e_rd = 4'd0;
            end else begin
                e_rv = 1'b0;
                if (m_post == 0) begin
                    if (pix_valid && e_ready) begin
                        img[m_ld] = pix_data;
                        m_ld++;
                        if (m_ld == NPIX) begin
                            m_ld   = 0;
                            m_post = 1;
                        end
                    end
                end else if (m_post > RST + NPIX) begin
                    w = m_post - RST - NPIX - 1;
                    if (cnn_valid) begin
                        e_rv = 1'b1; e_rd = cnn_decision; e_re = 1'b0; m_post = 0;
                    end else if (w == TO - 1) begin
                        e_rv = 1'b1; e_rd = 4'hF; e_re = 1'b1; m_post = 0;
                    end else begin
                        m_post++;
                    end
                end else begin
                    m_post++;
                end
                e_ready = (m_post == 0);
                e_busy  = (m_post != 0) || (m_ld != 0);
                e_crst  = (m_post > RST);
                e_data  = (m_post > RST && m_post <= RST + NPIX) ? img[m_post - RST - 1] : 8'd0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("pix_ready", pix_ready, e_ready);
                check("cnn_rst_n", cnn_rst_n, e_crst);
                check("cnn_data", cnn_data, e_data);
                check("busy", busy, e_busy);
                check("result_valid", result_valid, e_rv);
                check("result_digit", result_digit, e_rd);
                check("result_err", result_err, e_re);
                if (result_valid) rv_seen++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && pix_valid && pix_ready) wr_seen++;
        end
    end

    task automatic load_image(input bit gaps, input bit pat);
        int i = 0;
        int g = 0;
        while (i < NPIX && g < 4000) begin
            @(negedge clk);
            g++;
            if (!gaps || (g % 2 == 1)) begin
                pix_valid = 1'b1;
                pix_data  = pat ? 8'((i * 7 + 3) % 256) : 8'(i % 256);
                if (pix_ready) i++;
            end else begin
                pix_valid = 1'b0;
            end
        end
        check("load_count", i, NPIX);
        @(negedge clk);
        pix_valid = 1'b0;
        check("ready_after_load", pix_ready, 1'b0);
    endtask

    task automatic stream_wait();
        int c = 1;
        while (!cnn_rst_n && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("flush_latency", c, RST + 1);
    endtask

    initial begin
        int c;
        pix_valid = 1'b0; pix_data = 8'd0; cnn_valid = 1'b0; cnn_decision = 4'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        repeat (100) @(negedge clk);
        check("idle_ready", pix_ready, 1'b1);
        check("idle_crst", cnn_rst_n, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_no_result", rv_seen, 0);

        // Contiguous load, stream, valid decision 7
        load_image(1'b0, 1'b0);
        stream_wait();
        check("stream0", cnn_data, 8'd0);
        repeat (300) @(negedge clk);
        check("stream300", cnn_data, 8'd44);
        repeat (494) @(negedge clk);
        cnn_decision = 4'd7; cnn_valid = 1'b1;
        @(negedge clk);
        check("res7_valid", result_valid, 1'b1);
        check("res7_digit", result_digit, 4'd7);
        check("res7_err", result_err, 1'b0);
        cnn_valid = 1'b0;
        @(negedge clk);
        check("res7_pulse_len", result_valid, 1'b0);
        check("res7_idle_busy", busy, 1'b0);
        cnn_decision = 4'd9; cnn_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_valid_ignored", result_valid, 1'b0);
        end
        cnn_valid = 1'b0;

        // Gapped load, pure timeout
        wr_seen = 0;
        load_image(1'b1, 1'b0);
        stream_wait();
        check("gap_writes", wr_seen, NPIX);
        repeat (783) @(negedge clk);
        check("stream783", cnn_data, 8'd15);
        @(negedge clk);
        check("after_stream", cnn_data, 8'd0);
        c = 784;
        while (!result_valid && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("timeout_latency", c, NPIX + TO);
        check("timeout_digit", result_digit, 4'hF);
        check("timeout_err", result_err, 1'b1);

        // Valid decision on the timeout cycle wins
        load_image(1'b0, 1'b0);
        stream_wait();
        repeat (NPIX + TO - 1) @(negedge clk);
        check("pre_timeout_quiet", result_valid, 1'b0);
        cnn_decision = 4'd3; cnn_valid = 1'b1;
        @(negedge clk);
        check("tie_valid", result_valid, 1'b1);
        check("tie_digit", result_digit, 4'd3);
        check("tie_err", result_err, 1'b0);
        cnn_valid = 1'b0;

        // Reset mid-stream, then reload a different image
        load_image(1'b0, 1'b0);
        stream_wait();
        repeat (400) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", pix_ready, 1'b0);
        check("rst_crst", cnn_rst_n, 1'b0);
        check("rst_data", cnn_data, 8'd0);
        check("rst_rv", result_valid, 1'b0);
        check("rst_digit", result_digit, 4'd0);
        check("rst_err", result_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", pix_ready, 1'b1);
        load_image(1'b0, 1'b1);
        stream_wait();
        check("reload_pix0", cnn_data, 8'd3);
        @(negedge clk);
        check("reload_pix1", cnn_data, 8'd10);
        repeat (NPIX + 9) @(negedge clk);
        cnn_decision = 4'd5; cnn_valid = 1'b1;
        @(negedge clk);
        check("res5_valid", result_valid, 1'b1);
        check("res5_digit", result_digit, 4'd5);
        cnn_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
